// File: rtl/encoder_seq_ctrl.sv
// Sequence controller around the shared encoder: loads one sequence, runs it through
// NUM_PASSES stacked encoder layers via ping-pong banks, then streams the result out.
module encoder_seq_ctrl #(
    parameter int DATA_W     = 16,
    parameter int SEQ_LEN    = 30,
    parameter int NUM_PASSES = 4,
    parameter int RST_CYC    = 2,
    parameter int TIMEOUT    = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              enc_rst_n,
    output logic [DATA_W-1:0] enc_data_in,
    output logic              enc_data_in_valid,
    output logic [2:0]        enc_block_sel,
    input  logic [DATA_W-1:0] enc_data_out,
    input  logic              enc_data_out_valid,
    input  logic              enc_done,
    output logic              busy,
    output logic              err,
    output logic [2:0]        dbg_state
);
    localparam int IW = $clog2(SEQ_LEN + 1);
    localparam int RW = $clog2(RST_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_RST_ENC = 3'd1,
        S_FEED    = 3'd2,
        S_WAIT    = 3'd3,
        S_NEXT    = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] bank [2][SEQ_LEN];
    logic              cur;
    logic [3:0]        pass;
    logic [IW-1:0]     wr_idx, rd_idx, cap_idx, feed_idx, feed_sel, cap_fill;
    logic [RW-1:0]     rst_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic              capturing;

    // Both streams: a word transfers on a rising clk edge where valid && ready;
    // valid never depends on ready, and data/last are held while valid && !ready.
    always_comb begin
        state_n   = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_data    = '0;
        feed_sel  = (state == S_FEED) ? feed_idx + IW'(1) : '0;
        capturing = (state == S_FEED) || (state == S_WAIT);
        cap_fill  = cap_idx + IW'(enc_data_out_valid && (cap_idx < IW'(SEQ_LEN)));
        case (state)
            S_LOAD: begin
                s_ready = 1'b1;
                if (s_valid && wr_idx == IW'(SEQ_LEN - 1)) state_n = S_RST_ENC;
            end
            S_RST_ENC: if (rst_cnt == RW'(RST_CYC - 1)) state_n = S_FEED;
            S_FEED:    if (feed_idx == IW'(SEQ_LEN - 1)) state_n = S_WAIT;
            S_WAIT: begin
                if (enc_done)                          state_n = S_NEXT;
                else if (tmo_cnt == TW'(TIMEOUT - 1))  state_n = S_LOAD;
            end
            S_NEXT: state_n = (pass == 4'(NUM_PASSES - 1)) ? S_DRAIN : S_RST_ENC;
            S_DRAIN: begin
                m_valid = 1'b1;
                m_data  = bank[cur][rd_idx];
                m_last  = (rd_idx == IW'(SEQ_LEN - 1));
                if (m_ready && m_last) state_n = S_LOAD;
            end
            default: state_n = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_n;
    end

    assign busy          = (state != S_LOAD);
    assign enc_block_sel = pass[2:0];
    assign dbg_state     = state;

    // Encoder-facing outputs are registered from the next state so they line up
    // exactly with the cycles spent in RST_ENC and FEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur               <= 1'b0;
            pass              <= '0;
            wr_idx            <= '0;
            rd_idx            <= '0;
            cap_idx           <= '0;
            feed_idx          <= '0;
            rst_cnt           <= '0;
            tmo_cnt           <= '0;
            err               <= 1'b0;
            enc_rst_n         <= 1'b0;
            enc_data_in_valid <= 1'b0;
            enc_data_in       <= '0;
        end else begin
            enc_rst_n         <= (state_n != S_RST_ENC);
            enc_data_in_valid <= (state_n == S_FEED);
            if (state_n == S_FEED) enc_data_in <= bank[cur][feed_sel];
            case (state)
                S_LOAD: if (s_valid) begin
                    if (wr_idx == '0) err <= 1'b0;
                    if (wr_idx == IW'(SEQ_LEN - 1)) begin
                        wr_idx  <= '0;
                        pass    <= '0;
                        rst_cnt <= '0;
                    end else begin
                        wr_idx <= wr_idx + IW'(1);
                    end
                end
                S_RST_ENC: begin
                    rst_cnt  <= rst_cnt + RW'(1);
                    cap_idx  <= '0;
                    feed_idx <= '0;
                end
                S_FEED: begin
                    feed_idx <= feed_idx + IW'(1);
                    tmo_cnt  <= '0;
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (enc_done) begin
                        if (cap_fill != IW'(SEQ_LEN)) err <= 1'b1;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        err    <= 1'b1;
                        wr_idx <= '0;
                    end
                end
                S_NEXT: begin
                    cur     <= ~cur;
                    pass    <= pass + 4'd1;
                    rst_cnt <= '0;
                    rd_idx  <= '0;
                end
                S_DRAIN: if (m_ready) rd_idx <= rd_idx + IW'(1);
                default: ;
            endcase
            // Encoder results beyond one full sequence are dropped and flagged.
            if (capturing && enc_data_out_valid) begin
                if (cap_idx < IW'(SEQ_LEN)) cap_idx <= cap_idx + IW'(1);
                else                        err     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < SEQ_LEN; i++)
                    bank[b][i] <= '0;
        end else if (state == S_LOAD && s_valid) begin
            bank[cur][wr_idx] <= s_data;
        end else if (capturing && enc_data_out_valid && cap_idx < IW'(SEQ_LEN)) begin
            bank[~cur][cap_idx] <= enc_data_out;
        end
    end
endmodule

// File: doc/encoder_seq_ctrl.md
# encoder_seq_ctrl

Sequence controller that sits in front of and behind the shared `encoder` block. It loads one 30-step sequence of 16-bit words from an upstream valid/ready stream. It then runs that sequence through the encoder `NUM_PASSES` times, once per stacked layer: `block_sel` = pass index, each pass's output is fed back as the next pass's input, and the encoder gets a local reset between passes. The final 30 words go out on a downstream valid/ready stream with a last flag.

## Interface
- `DATA_W`, 16, word width; must match the encoder.
- `SEQ_LEN`, 30, words per sequence.
- `NUM_PASSES`, 4, encoder layers to run, range 1..8.
- `RST_CYC`, 2, cycles `enc_rst_n` is held low before each pass, ≥1.
- `TIMEOUT`, 1000000, max cycles in WAIT before abort.

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_data`  in  DATA_W  upstream word.
- `s_valid`  in  1  upstream valid.
- `s_ready`  out  1  high only in LOAD.
- `m_data`  out  DATA_W  result word.
- `m_valid`  out  1  high only in DRAIN.
- `m_ready`  in  1  downstream ready.
- `m_last`  out  1  high with the SEQ_LEN-th `m_data`.
- `enc_rst_n`  out  1  registered encoder-local reset, active-low.
- `enc_data_in`  out  DATA_W  word to encoder `data_in`, registered.
- `enc_data_in_valid`  out  1  to encoder `data_in_valid`, registered.
- `enc_block_sel`  out  3  to encoder `block_sel`; equals the pass index.
- `enc_data_out`  in  DATA_W  encoder `data_out`.
- `enc_data_out_valid`  in  1  encoder `data_out_valid`.
- `enc_done`  in  1  encoder `done`, level.
- `busy`  out  1  state ≠ LOAD.
- `err`  out  1  sticky; cleared only by `rst_n` or the next accepted load word 0.

## Operation
- Storage: two banks of SEQ_LEN × DATA_W registers. `cur` selects the feed bank; the capture bank is `~cur`.
- States: LOAD → RST_ENC → FEED → WAIT → NEXT → (RST_ENC | DRAIN) → LOAD.
- **LOAD:**
  - `s_ready`=1.
  - Each `s_valid&&s_ready` writes bank[cur][wr_idx] and increments `wr_idx`.
  - On the SEQ_LEN-th handshake: `pass`←0, go to RST_ENC.
- **RST_ENC:**
  - `enc_rst_n`=0 for exactly RST_CYC cycles; `enc_block_sel`=`pass`.
  - Capture index is cleared. Then go to FEED.
- **FEED:**
  - Exactly SEQ_LEN consecutive cycles with `enc_data_in_valid`=1.
  - `enc_data_in` = bank[cur][0..SEQ_LEN-1] in order. Then go to WAIT.
- **WAIT (capture is also active during FEED):**
  - Each `enc_data_out_valid` writes `enc_data_out` to bank[~cur][cap_idx], and `cap_idx` increments.
  - Valids beyond SEQ_LEN are dropped and set `err`.
  - On `enc_done`=1: if `cap_idx`≠SEQ_LEN, set `err` (uncaptured entries keep stale data). Go to NEXT.
  - Timeout counter clears on WAIT entry. Reaching TIMEOUT sets `err`, discards the sequence and goes to LOAD with `wr_idx`=0.
- **NEXT:** one cycle; `cur`←~`cur`, `pass`←`pass`+1. If the new `pass`=NUM_PASSES go to DRAIN, else go to RST_ENC.
- **DRAIN:**
  - `m_data`=bank[cur][rd_idx], `m_valid`=1, `m_last`=(rd_idx=SEQ_LEN-1).
  - Advance `rd_idx` on handshake. After the last handshake go to LOAD.
- `enc_block_sel` holds `pass` from RST_ENC through WAIT.
- There is no arithmetic on data; counters are $clog2(SEQ_LEN+1) wide and never wrap.

## Timing
- Reset values:
  - state=LOAD, so `s_ready`=1 once `rst_n` is high.
  - `m_valid`=0, `m_last`=0, `m_data`=0.
  - `enc_rst_n`=0, `enc_data_in_valid`=0, `enc_data_in`=0, `enc_block_sel`=0.
  - `busy`=0, `err`=0; banks cleared.
- `enc_rst_n` rises on the first clock after `rst_n` deasserts.
- The cycle after the last load handshake, `enc_rst_n`=0 and stays low RST_CYC cycles.
- `enc_data_in_valid` rises on the cycle `enc_rst_n` returns high.
- Per-pass overhead outside the encoder: RST_CYC + SEQ_LEN + 1 (NEXT) + 1 (WAIT exit) cycles.
- DRAIN first `m_valid` is 1 cycle after NEXT. With `m_ready`=1 throughout, SEQ_LEN words take SEQ_LEN cycles.
- `m_data`/`m_last` hold stable while `m_valid`&&!`m_ready`.
- `enc_done` is sampled only in WAIT; stale high from a previous pass is ignored because RST_ENC resets the encoder.
- If `enc_done` and the final `enc_data_out_valid` arrive in the same cycle, the word is captured and counted before the completeness check.
- `rst_n` asserted mid-operation: all outputs go to their reset values immediately and any in-flight sequence is lost.

## Test plan
- **Single pass:** NUM_PASSES=1, encoder model returns x+1 after 200 cycles. Load 0..29 → `enc_block_sel`=0, feed of 0..29 in 30 consecutive cycles, then `m_data` 1..30, `m_last` only with 30, `err`=0.
- **Multi-pass:** NUM_PASSES=3, same model → `enc_block_sel` steps 0,1,2. `enc_rst_n` is low 2 cycles before each FEED. Output 3..32.
- **Backpressure:** random 50% gaps on `s_valid` and `m_ready` → exactly 30 loaded and 30 drained, no duplicates or drops; `m_data` stable while stalled.
- **Short capture:** model gives 29 valids then `enc_done` → `err`=1, 30 words still drained, word 29 = stale bank content.
- **Timeout:** TIMEOUT=500, model never asserts `enc_done` → `err`=1 exactly 500 cycles after WAIT entry, `s_ready`=1 next cycle, `m_valid` never rises.
- **Reset mid-FEED:** pulse `rst_n` at feed word 10 → all outputs at reset values within the pulse. A fresh load then completes correctly with `err`=0.
